// File: rtl/uart_tx_buffered_if.sv
// Byte producer <-> buffered UART transmitter: push strobe, data and status.
// Signal names match the original flat port list so callers only re-wire.
interface uart_tx_buffered_if #(
   parameter int DEPTH = 4
);
   logic [7:0]             i_data;
   logic                   i_send;
   logic                   o_tx;
   logic                   o_busy;
   logic                   o_full;
   logic [$clog2(DEPTH):0] o_count;
   logic                   o_overflow;

   modport master (
      output i_data, i_send,
      input  o_tx, o_busy, o_full, o_count, o_overflow
   );

   modport slave (
      input  i_data, i_send,
      output o_tx, o_busy, o_full, o_count, o_overflow
   );
endinterface

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a DEPTH-entry byte FIFO.
// Overflow is sticky and clears only on reset.
module uart_tx_buffered #(
   parameter int CLKS_PER_BIT = 2703,
   parameter int DEPTH        = 4
) (
   input  logic               clk,
   input  logic               reset,
   uart_tx_buffered_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);

   typedef logic [AW:0] cnt_t;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic            tx_q, tx_d;
   logic [CW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   cnt_t            count_q, count_d;
   logic            ovf_q, ovf_d;
   logic [7:0]      mem_q [DEPTH];

   logic            full;
   logic            push;
   logic            pop;
   logic            bit_end;

   assign full    = (count_q == cnt_t'(DEPTH));
   assign push    = bus.i_send && !full;
   assign pop     = (state_q == IDLE) && (count_q != '0);
   assign bit_end = (baud_q == CW'(CLKS_PER_BIT - 1));

   // A full FIFO drops the push even when a pop frees a slot on the same edge.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q | (bus.i_send & full);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + cnt_t'(1);
         2'b01:   count_d = count_q - cnt_t'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (pop) begin
               state_d = START;
               tx_d    = 1'b0;
               baud_d  = '0;
               bit_d   = '0;
               shreg_d = mem_q[rd_ptr_q];
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               tx_d    = shreg_q[0];
               baud_d  = '0;
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  // Next bit is taken from shreg_q[1] as the shift lands on this edge.
                  bit_d   = bit_q + 3'd1;
                  shreg_d = {1'b0, shreg_q[7:1]};
                  tx_d    = shreg_q[1];
               end
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         STOP: begin
            tx_d = 1'b1;
            if (bit_end) begin
               state_d = IDLE;
               baud_d  = '0;
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         tx_q     <= 1'b1;
         baud_q   <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tx_q     <= tx_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push) mem_q[wr_ptr_q] <= bus.i_data;
   end

   assign bus.o_tx       = tx_q;
   assign bus.o_busy     = (state_q != IDLE) || (count_q != '0);
   assign bus.o_full     = full;
   assign bus.o_count    = count_q;
   assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: directed scenarios plus random traffic
// compared cycle by cycle against a queue-and-timeline model of the serial line.
module tb_uart_tx_buffered;
   localparam int C     = 4;
   localparam int D     = 4;
   localparam int FRAME = 10 * C;
   localparam int CWD   = $clog2(D) + 1;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   uart_tx_buffered_if #(.DEPTH(D)) bus ();

   uart_tx_buffered #(.CLKS_PER_BIT(C), .DEPTH(D)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: FIFO as a queue; the line is a function of time since the frame began.
   logic [7:0] mq [$];
   int         e = 0;
   bit         have_frame = 0;
   int         f_start = 0;
   logic [7:0] f_data = '0;
   bit         m_ovf = 0;
   logic       x_tx, x_busy, x_full, x_ovf;
   int         x_count;

   task automatic model_edge(input bit s, input logic [7:0] d, input bit r);
      bit was_full;
      bit act;
      int k;
      e++;
      if (r) begin
         mq.delete();
         have_frame = 0;
         m_ovf      = 0;
      end else begin
         was_full = (mq.size() == D);
         if (mq.size() > 0 && (!have_frame || e >= f_start + FRAME + 1)) begin
            f_data     = mq.pop_front();
            f_start    = e;
            have_frame = 1;
         end
         if (s) begin
            if (was_full) m_ovf = 1;
            else mq.push_back(d);
         end
      end
      if (have_frame && e < f_start + FRAME) begin
         k    = (e - f_start) / C;
         x_tx = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : f_data[k-1];
         act  = 1;
      end else begin
         x_tx = 1'b1;
         act  = 0;
      end
      x_count = mq.size();
      x_busy  = act || (x_count != 0);
      x_full  = (x_count == D);
      x_ovf   = m_ovf;
   endtask

   // One clock: drive inputs, advance the model on the edge, return at the falling edge.
   task automatic cycle(input bit s, input logic [7:0] d, input bit r);
      bus.i_send = s;
      bus.i_data = d;
      rst        = r;
      @(posedge clk);
      model_edge(s, d, r);
      @(negedge clk);
   endtask

   function automatic logic [CWD+3:0] got_v();
      return {bus.o_tx, bus.o_busy, bus.o_full, bus.o_count, bus.o_overflow};
   endfunction

   function automatic logic [CWD+3:0] exp_v();
      return {x_tx, x_busy, x_full, CWD'(x_count), x_ovf};
   endfunction

   task automatic test_reset();
      cycle(0, 8'h00, 1);
      cycle(1, 8'h99, 1);
      checks++;
      if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_full !== 1'b0 ||
          bus.o_count !== '0 || bus.o_overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got tx=%b busy=%b full=%b cnt=%0d ovf=%b required 1 0 0 0 0",
                  bus.o_tx, bus.o_busy, bus.o_full, bus.o_count, bus.o_overflow);
      end
      cycle(0, 8'h00, 0);
      checks++;
      if (got_v() !== exp_v()) begin
         failures++;
         $display("FAIL reset_ignore_send e=%0d got=%b required=%b", e, got_v(), exp_v());
      end
   endtask

   task automatic test_single();
      int fall = -1;
      cycle(1, 8'hA5, 0);
      for (int j = 1; j <= 50; j++) begin
         cycle(0, 8'h00, 0);
         checks++;
         if (got_v() !== exp_v()) begin
            failures++;
            $display("FAIL single_line j=%0d got=%b required=%b", j, got_v(), exp_v());
         end
         if (fall < 0 && bus.o_busy === 1'b0) fall = j;
      end
      checks++;
      if (fall !== 41) begin
         failures++;
         $display("FAIL single_busy_fall got=%0d required=41", fall);
      end
   endtask

   task automatic test_fill_overflow();
      int exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
      for (int i = 0; i < 6; i++) begin
         cycle(1, 8'(8'h11 + i), 0);
         checks++;
         if (bus.o_count !== CWD'(exp_cnt[i]) || bus.o_full !== (i >= 4) ||
             bus.o_overflow !== (i == 5)) begin
            failures++;
            $display("FAIL fill_push%0d got cnt=%0d full=%b ovf=%b required cnt=%0d full=%b ovf=%b",
                     i, bus.o_count, bus.o_full, bus.o_overflow, exp_cnt[i], i >= 4, i == 5);
         end
         checks++;
         if (got_v() !== exp_v()) begin
            failures++;
            $display("FAIL fill_model e=%0d got=%b required=%b", e, got_v(), exp_v());
         end
      end
      for (int j = 0; j < 260; j++) begin
         cycle(0, 8'h00, 0);
         checks++;
         if (got_v() !== exp_v()) begin
            failures++;
            $display("FAIL fill_drain e=%0d got=%b required=%b", e, got_v(), exp_v());
         end
      end
      checks++;
      if (bus.o_overflow !== 1'b1 || bus.o_busy !== 1'b0) begin
         failures++;
         $display("FAIL overflow_sticky got ovf=%b busy=%b required ovf=1 busy=0",
                  bus.o_overflow, bus.o_busy);
      end
      cycle(0, 8'h00, 1);
      checks++;
      if (bus.o_overflow !== 1'b0) begin
         failures++;
         $display("FAIL overflow_clear got=%b required=0", bus.o_overflow);
      end
      cycle(0, 8'h00, 0);
   endtask

   task automatic test_extremes();
      logic tr [91];
      logic bz [91];
      int   lows1 = 0, lows2 = 0, highs2 = 0;
      for (int j = 0; j <= 90; j++) begin
         cycle(j < 2, (j == 0) ? 8'h00 : 8'hFF, 0);
         tr[j] = bus.o_tx;
         bz[j] = bus.o_busy;
         checks++;
         if (got_v() !== exp_v()) begin
            failures++;
            $display("FAIL extremes_line j=%0d got=%b required=%b", j, got_v(), exp_v());
         end
      end
      for (int j = 1; j <= 41; j++)  if (tr[j] === 1'b0) lows1++;
      for (int j = 42; j <= 81; j++) if (tr[j] === 1'b0) lows2++;
      for (int j = 46; j <= 81; j++) if (tr[j] === 1'b1) highs2++;
      checks++;
      if (lows1 !== 36 || lows2 !== 4 || highs2 !== 36 || bz[82] !== 1'b0) begin
         failures++;
         $display("FAIL extremes_runs got low00=%0d lowFF=%0d highFF=%0d busy82=%b required 36 4 36 0",
                  lows1, lows2, highs2, bz[82]);
      end
   endtask

   task automatic test_reset_midframe();
      cycle(1, 8'h3C, 0);
      cycle(1, 8'h7E, 0);
      for (int j = 2; j <= 17; j++) cycle(0, 8'h00, 0);
      cycle(0, 8'h00, 1);
      checks++;
      if (bus.o_tx !== 1'b1 || bus.o_count !== '0 || bus.o_busy !== 1'b0) begin
         failures++;
         $display("FAIL midframe_reset got tx=%b cnt=%0d busy=%b required 1 0 0",
                  bus.o_tx, bus.o_count, bus.o_busy);
      end
      for (int j = 0; j < 60; j++) begin
         cycle(0, 8'h00, 0);
         checks++;
         if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 || got_v() !== exp_v()) begin
            failures++;
            $display("FAIL midframe_quiet j=%0d got=%b required=%b", j, got_v(), exp_v());
         end
      end
   endtask

   task automatic test_stop_push();
      cycle(1, 8'h81, 0);
      for (int j = 1; j <= 100; j++) begin
         cycle(j == 38, 8'h55, 0);
         checks++;
         if (got_v() !== exp_v()) begin
            failures++;
            $display("FAIL stop_push_line j=%0d got=%b required=%b", j, got_v(), exp_v());
         end
         if (j == 41 || j == 42) begin
            checks++;
            if (bus.o_tx !== (j == 41) || bus.o_count !== CWD'(j == 41)) begin
               failures++;
               $display("FAIL stop_push_restart j=%0d got tx=%b cnt=%0d required tx=%b cnt=%0d",
                        j, bus.o_tx, bus.o_count, j == 41, j == 41);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      cycle(1, 8'hC3, 0);
      cycle(1, 8'h5A, 0);
      checks++;
      if (bus.o_count !== CWD'(1) || bus.o_tx !== 1'b0) begin
         failures++;
         $display("FAIL simul_pushpop got cnt=%0d tx=%b required cnt=1 tx=0", bus.o_count, bus.o_tx);
      end
      for (int j = 2; j <= 95; j++) begin
         cycle(0, 8'h00, 0);
         checks++;
         if (got_v() !== exp_v()) begin
            failures++;
            $display("FAIL simul_line j=%0d got=%b required=%b", j, got_v(), exp_v());
         end
         if (j == 82) begin
            checks++;
            if (bus.o_busy !== 1'b0) begin
               failures++;
               $display("FAIL simul_done got busy=%b required 0", bus.o_busy);
            end
         end
      end
   endtask

   task automatic test_random();
      int burst = 0;
      bit s, r;
      for (int i = 0; i < 2400; i++) begin
         if (burst == 0 && $urandom_range(0, 99) < 3) burst = $urandom_range(1, 8);
         s = (burst > 0) || ($urandom_range(0, 9) == 0);
         if (burst > 0) burst--;
         r = (i < 2000) && ($urandom_range(0, 499) == 0);
         cycle(s && i < 2000, 8'($urandom), r);
         checks++;
         if (got_v() !== exp_v()) begin
            failures++;
            $display("FAIL random e=%0d got=%b required=%b", e, got_v(), exp_v());
         end
      end
   endtask

   initial begin
      bus.i_send = 1'b0;
      bus.i_data = '0;
      rst        = 1'b1;
      test_reset();
      test_single();
      test_fill_overflow();
      test_extremes();
      test_reset_midframe();
      test_stop_push();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at e=%0d required completion", e);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 2703, giving clk cycles per UART bit; legal values are 2 and above.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving FIFO entries; legal values are powers of two, 2 to 16.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port i_data, input, 8 bits: byte to enqueue.
REQ-006 The block SHALL have port i_send, input, 1 bit: push strobe, one byte per sampled high cycle (caller feeds it from single_pulser).
REQ-007 The block SHALL have port o_tx, output, 1 bit: registered serial line, idle high.
REQ-008 The block SHALL have port o_busy, output, 1 bit: high while the FIFO is non-empty or a frame is in progress.
REQ-009 The block SHALL have port o_full, output, 1 bit: high when FIFO count equals DEPTH.
REQ-010 The block SHALL have port o_count, output, clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-011 The block SHALL have port o_overflow, output, 1 bit: sticky flag for a dropped push.

Function
REQ-012 Frame format SHALL be 8N1: start bit 0, data bits LSB first, one stop bit 1; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-013 A push SHALL be accepted on an edge where i_send=1 and o_full=0; i_data is written at the tail.
REQ-014 A push on an edge where o_full=1 SHALL be dropped and SHALL set o_overflow, even if a pop occurs on the same edge.
REQ-015 A push and a pop on the same edge SHALL leave o_count unchanged and SHALL preserve FIFO order.
REQ-016 FIFO read/write pointers SHALL wrap modulo DEPTH; o_count SHALL never exceed DEPTH or go below 0.
REQ-017 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-018 In IDLE with o_count>0, the FSM SHALL pop the head into an 8-bit shift register on the next edge, enter START, and drive o_tx=0 from that edge.
REQ-019 In IDLE with o_count=0, the FSM SHALL hold o_tx=1.
REQ-020 START SHALL transition to DATA after CLKS_PER_BIT cycles, with o_tx = bit 0.
REQ-021 DATA SHALL shift out bits 0..7, each held CLKS_PER_BIT cycles, using a 3-bit bit index, then enter STOP with o_tx=1.
REQ-022 STOP SHALL hold o_tx=1 for CLKS_PER_BIT cycles, then return to IDLE; IDLE SHALL last at least 1 cycle before the next pop.
REQ-023 Latency SHALL be: i_send sampled at edge E0 into an empty, idle block gives o_tx falling at edge E1.
REQ-024 Back-to-back frames SHALL be separated by exactly CLKS_PER_BIT+1 high cycles (stop bit plus 1 IDLE cycle).
REQ-025 The baud counter SHALL count 0..CLKS_PER_BIT-1 and reload at each bit boundary, with no cumulative drift.
REQ-026 o_busy SHALL equal (state != IDLE) OR (o_count != 0).

Reset
REQ-027 On an edge with reset=1, the block SHALL set state=IDLE, o_tx=1, FIFO empty (pointers and o_count=0), o_full=0, o_busy=0, o_overflow=0, and clear the baud counter and bit index.
REQ-028 Reset asserted mid-frame SHALL abort the frame: o_tx=1 from the reset edge, no partial bits resumed, queued bytes discarded.
REQ-029 i_send sampled while reset=1 SHALL be ignored.
REQ-030 o_overflow SHALL clear only on reset.

Verification (CLKS_PER_BIT=4, DEPTH=4)
REQ-031 Single byte: push 0xA5 at E0 -> o_tx low from E1 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; o_busy falls at E41.
REQ-032 Fill and overflow: push 0x11..0x16 on 6 consecutive edges -> o_count sequence 1,1,2,3,4 with o_full=1 after the fifth push; 0x16 dropped, o_overflow=1; line carries 0x11..0x15 in order with 5-cycle high gaps between frames.
REQ-033 Extremes: push 0x00 then 0xFF -> 0x00 frame shows 36 low cycles then stop; 0xFF frame shows 4 low cycles then 36 high cycles.
REQ-034 Reset mid-frame: push 0x3C and 0x7E; assert reset during bit 3 of the first frame -> o_tx=1 from the reset edge, o_count=0, o_busy=0; no further frame until a new push.
REQ-035 Push during STOP: push 0x55 while STOP of a prior frame is active -> new start bit exactly 1 cycle after STOP ends, o_count returns to 0 on the pop edge.
REQ-036 Simultaneous push/pop: with o_count=1 in IDLE, push on the pop edge -> o_count stays 1 and both bytes transmit in order.
